// File: rtl/w5300_slave_model.sv
// Clocked bus-slave model of the W5300 host interface: register array, W1C interrupt pair and a transaction log.
// Define W5300_MODEL_LOG_EN to build the log FIFO; otherwise the log outputs are tied to 0.
module w5300_slave_model #(
  parameter int unsigned       ADDR_W    = 10,
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       LOG_DEPTH = 8,
  parameter logic [ADDR_W-1:0] IMR_ADDR  = ADDR_W'(0),
  parameter logic [ADDR_W-1:0] IR_ADDR   = ADDR_W'(2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              cs_n,
  input  logic              rd_n,
  input  logic              wr_n,
  inout  wire  [DATA_W-1:0] d,
  output logic              int_n,
  input  logic [DATA_W-1:0] int_set,
  input  logic              log_pop,
  input  logic              log_clr,
  output logic              log_valid,
  output logic              log_rnw,
  output logic [ADDR_W-1:0] log_addr,
  output logic [DATA_W-1:0] log_data,
  output logic              log_overflow,
  output logic              err_both
);

  localparam int unsigned MEM_DEPTH = 2 ** ADDR_W;
  localparam int unsigned LOG_W     = 1 + ADDR_W + DATA_W;

  logic              rd_raw, wr_raw;
  logic [2:0]        rd_sync, wr_sync;
  logic              rd_fall, wr_fall, busy;
  logic              rd_commit, wr_commit;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_data;
  logic              cap_bad;
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] imr;
  logic [DATA_W-1:0] rd_val;

  assign rd_raw = ~(cs_n | rd_n);
  assign wr_raw = ~(cs_n | wr_n);
  assign imr    = mem[IMR_ADDR];

  // Read data source: IR lives outside the array, everything else is plain storage.
  always_comb begin
    rd_val = mem[addr];
    if (addr == IR_ADDR) rd_val = ir;
  end

  assign d = rd_raw ? rd_val : {DATA_W{1'bz}};

  // s1 = [0], s2 = [1], s3 = [2]; a transaction completes when s2 falls.
  assign rd_fall   = ~rd_sync[1] & rd_sync[2];
  assign wr_fall   = ~wr_sync[1] & wr_sync[2];
  assign busy      = rd_raw | wr_raw | rd_sync[0] | rd_sync[1] | wr_sync[0] | wr_sync[1];
  assign rd_commit = rd_fall & ~cap_bad;
  assign wr_commit = wr_fall & ~cap_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_sync  <= '0;
      wr_sync  <= '0;
      cap_addr <= '0;
      cap_data <= '0;
      cap_bad  <= 1'b0;
      err_both <= 1'b0;
    end else begin
      rd_sync <= {rd_sync[1:0], rd_raw};
      wr_sync <= {wr_sync[1:0], wr_raw};
      if (rd_raw || wr_raw) begin
        cap_addr <= addr;
        cap_data <= wr_raw ? d : rd_val;
      end
      // A contended capture stays bad until every strobe chain has drained.
      if (rd_raw && wr_raw) begin
        cap_bad  <= 1'b1;
        err_both <= 1'b1;
      end else if ((rd_fall || wr_fall) && !busy) begin
        cap_bad <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (wr_commit && (cap_addr != IR_ADDR)) begin
      mem[cap_addr] <= cap_data;
    end
  end

  // IR is write-1-to-clear; a same-edge set request wins over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir    <= '0;
      int_n <= 1'b1;
    end else begin
      if (wr_commit && (cap_addr == IR_ADDR)) ir <= (ir & ~cap_data) | int_set;
      else                                    ir <= ir | int_set;
      int_n <= ~|(ir & imr);
    end
  end

`ifdef W5300_MODEL_LOG_EN
  localparam int unsigned PTR_W = $clog2(LOG_DEPTH);

  logic [LOG_W-1:0] fifo [LOG_DEPTH];
  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic             push, empty, full, do_push, do_pop;
  logic [LOG_W-1:0] push_data;
  logic [LOG_W-1:0] head;

  assign push      = wr_commit | rd_commit;
  assign push_data = {rd_commit, cap_addr, cap_data};
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_pop    = log_pop & ~empty;
  // When full, a same-edge pop frees the slot the push lands in.
  assign do_push   = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      log_overflow <= 1'b0;
    end else if (log_clr) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      log_overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
      if (push && !do_push) log_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !log_clr) fifo[wr_ptr[PTR_W-1:0]] <= push_data;
  end

  assign head                          = fifo[rd_ptr[PTR_W-1:0]];
  assign log_valid                     = ~empty;
  assign {log_rnw, log_addr, log_data} = head;
`else
  logic unused_log;
  assign unused_log   = ^{log_pop, log_clr, rd_commit};
  assign log_valid    = 1'b0;
  assign log_rnw      = 1'b0;
  assign log_addr     = '0;
  assign log_data     = '0;
  assign log_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_w5300_slave_model.sv
// Scoreboard bench for w5300_slave_model: read data and log entries are predicted at issue and checked on output.
module tb_w5300_slave_model;
  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned LOG_DEPTH = 8;
  localparam int unsigned LOG_W     = 1 + ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] IMR_A = 10'h000;
  localparam logic [ADDR_W-1:0] IR_A  = 10'h002;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] addr;
  logic              cs_n, rd_n, wr_n;
  wire  [DATA_W-1:0] d;
  logic [DATA_W-1:0] d_drv;
  logic              d_en;
  logic              int_n;
  logic [DATA_W-1:0] int_set;
  logic              log_pop, log_clr;
  logic              log_valid, log_rnw, log_overflow, err_both;
  logic [ADDR_W-1:0] log_addr;
  logic [DATA_W-1:0] log_data;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] rd_q [$];
  logic [LOG_W-1:0]  log_q [$];
  logic [DATA_W-1:0] mdl [1024];
  logic [DATA_W-1:0] ir_m;
  logic [LOG_W-1:0]  junk;

  assign d = d_en ? d_drv : {DATA_W{1'bz}};

  always #5 clk = ~clk;

  w5300_slave_model #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOG_DEPTH(LOG_DEPTH),
    .IMR_ADDR(IMR_A), .IR_ADDR(IR_A)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
    .d(d), .int_n(int_n), .int_set(int_set), .log_pop(log_pop), .log_clr(log_clr),
    .log_valid(log_valid), .log_rnw(log_rnw), .log_addr(log_addr), .log_data(log_data),
    .log_overflow(log_overflow), .err_both(err_both)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Full write cycle; set/pop are applied on the completion edge.
  task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v,
                           input logic [DATA_W-1:0] set, input logic pop);
    @(negedge clk);
    addr = a; d_drv = v; d_en = 1'b1; cs_n = 1'b0; wr_n = 1'b0;
    repeat (4) @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1; d_en = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    int_set = set; log_pop = pop;
    @(negedge clk);
    int_set = '0; log_pop = 1'b0;
    repeat (2) @(negedge clk);
    if (a == IR_A) ir_m = (ir_m & ~v) | set;
    else begin
      mdl[a] = v;
      ir_m = ir_m | set;
    end
`ifdef W5300_MODEL_LOG_EN
    log_q.push_back({1'b0, a, v});
`endif
  endtask

  task automatic bus_read(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] exp;
    exp = (a == IR_A) ? ir_m : mdl[a];
    rd_q.push_back(exp);
`ifdef W5300_MODEL_LOG_EN
    log_q.push_back({1'b1, a, exp});
`endif
    @(negedge clk);
    addr = a; cs_n = 1'b0; rd_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rd_data", 32'(d), 32'(rd_q.pop_front()));
    repeat (2) @(negedge clk);
    cs_n = 1'b1; rd_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic pulse_set(input logic [DATA_W-1:0] v);
    @(negedge clk);
    int_set = v;
    @(negedge clk);
    int_set = '0;
    ir_m = ir_m | v;
    @(negedge clk);
  endtask

  task automatic log_drain(input string tag);
`ifdef W5300_MODEL_LOG_EN
    while (log_q.size() > 0) begin
      @(negedge clk);
      chk({tag, "_valid"}, 32'(log_valid), 32'd1);
      chk(tag, 32'({log_rnw, log_addr, log_data}), 32'(log_q.pop_front()));
      log_pop = 1'b1;
      @(negedge clk);
      log_pop = 1'b0;
    end
    chk({tag, "_empty"}, 32'(log_valid), 32'd0);
`else
    log_q.delete();
    chk({tag, "_valid0"}, 32'(log_valid), 32'd0);
    chk({tag, "_ovf0"}, 32'(log_overflow), 32'd0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] v;
    rst = 1'b1; addr = '0; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    d_drv = '0; d_en = 1'b0; int_set = '0; log_pop = 1'b0; log_clr = 1'b0;
    for (int i = 0; i < 1024; i++) mdl[i] = '0;
    ir_m = '0;
    repeat (3) @(negedge clk);
    chk("rst_int_n", 32'(int_n), 32'd1);
    chk("rst_log_valid", 32'(log_valid), 32'd0);
    chk("rst_log_ovf", 32'(log_overflow), 32'd0);
    chk("rst_err_both", 32'(err_both), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Write then read back
    bus_write(10'h123, 8'hA5, '0, 1'b0);
    bus_read(10'h123);
    log_drain("wr_rd");

    for (int i = 0; i < 3; i++) begin
      a = 10'h040 + 10'(i * 37);
      v = 8'($urandom);
      bus_write(a, v, '0, 1'b0);
      bus_read(a);
    end
    bus_read(10'h3FF);
    log_drain("pat");

    // Interrupt path
    bus_write(IMR_A, 8'h04, '0, 1'b0);
    chk("irq_idle", 32'(int_n), 32'd1);
    pulse_set(8'h04);
    chk("irq_assert", 32'(int_n), 32'd0);
    bus_read(IR_A);
    bus_write(IR_A, 8'h04, '0, 1'b0);
    chk("irq_w1c", 32'(int_n), 32'd1);
    bus_read(IR_A);
    log_drain("irq1");
    pulse_set(8'h04);
    chk("irq_assert2", 32'(int_n), 32'd0);
    bus_write(IR_A, 8'h04, 8'h04, 1'b0);
    chk("irq_set_wins", 32'(int_n), 32'd0);
    bus_read(IR_A);
    bus_read(IMR_A);
    bus_write(IR_A, 8'hFF, '0, 1'b0);
    chk("irq_clear", 32'(int_n), 32'd1);
    log_drain("irq2");

    // Overflow: the last push is dropped
    for (int i = 0; i < int'(LOG_DEPTH) + 1; i++)
      bus_write(10'h200 + 10'(i), 8'h10 + 8'(i), '0, 1'b0);
`ifdef W5300_MODEL_LOG_EN
    junk = log_q.pop_back();
    chk("ovf_set", 32'(log_overflow), 32'd1);
    log_drain("ovf");
    chk("ovf_sticky", 32'(log_overflow), 32'd1);
    bus_write(10'h210, 8'h5A, '0, 1'b0);
    @(negedge clk);
    log_clr = 1'b1;
    @(negedge clk);
    log_clr = 1'b0;
    log_q.delete();
    chk("clr_valid", 32'(log_valid), 32'd0);
    chk("clr_ovf", 32'(log_overflow), 32'd0);
`else
    log_drain("ovf");
`endif

    // Full FIFO: push and pop on the same edge
    for (int i = 0; i < int'(LOG_DEPTH); i++)
      bus_write(10'h300 + 10'(i), 8'(i * 3), '0, 1'b0);
`ifdef W5300_MODEL_LOG_EN
    chk("full_head", 32'({log_rnw, log_addr, log_data}), 32'(log_q[0]));
    junk = log_q.pop_front();
`endif
    bus_write(10'h3A0, 8'hC3, '0, 1'b1);
    chk("full_no_ovf", 32'(log_overflow), 32'd0);
    log_drain("full");

    // Contention: no commit, no log, sticky error
    @(negedge clk);
    addr = 10'h123; cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
    repeat (4) @(negedge clk);
    cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("both_err", 32'(err_both), 32'd1);
    chk("both_nolog", 32'(log_valid), 32'd0);
    bus_read(10'h123);
    chk("both_sticky", 32'(err_both), 32'd1);
    log_drain("both");

    // Reset in the middle of a write
    pulse_set(8'h04);
    chk("pre_rst_int", 32'(int_n), 32'd0);
    @(negedge clk);
    addr = 10'h155; d_drv = 8'h77; d_en = 1'b1; cs_n = 1'b0; wr_n = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1; d_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 1024; i++) mdl[i] = '0;
    ir_m = '0;
    log_q.delete();
    repeat (5) @(negedge clk);
    chk("mid_rst_int_n", 32'(int_n), 32'd1);
    chk("mid_rst_log", 32'(log_valid), 32'd0);
    chk("mid_rst_err", 32'(err_both), 32'd0);
    bus_read(10'h155);
    bus_read(10'h123);
    bus_read(IMR_A);
    log_drain("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
